teclado_ps2: RTL and testbench

TECLADO_PS2 -- requirements
Module: teclado_ps2

---
 rtl/teclado_ps2_if.sv | 17 +
 rtl/teclado_ps2.sv | 228 ++++++++++++++++++++++
 tb/tb_teclado_ps2.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/teclado_ps2_if.sv
// Consumer-side bus of the PS/2 keyboard receiver: scancode FIFO head, pop request and event pulses.
interface teclado_ps2_if;
  logic       rd_en;
  logic [7:0] dado;
  logic       break_flag;
  logic       extended;
  logic       valid;
  logic       erro;
  logic       overflow;

  // Handshake: the consumer pops the head entry by holding rd_en=1 at a rising Clock edge
  // while valid=1. rd_en is ignored while valid=0. dado/break_flag/extended are only
  // meaningful while valid=1 and read as 0 otherwise. erro and overflow are single-cycle
  // pulses that need no acknowledge.
  modport master (output rd_en, input dado, break_flag, extended, valid, erro, overflow);
  modport slave  (input rd_en, output dado, break_flag, extended, valid, erro, overflow);
endinterface

// File: rtl/teclado_ps2.sv
// PS/2 keyboard receiver: synchronizer, glitch filter, frame FSM with timeout,
// E0/F0 prefix folding and a show-ahead scancode FIFO.
module teclado_ps2 #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  teclado_ps2_if.slave  kbd,
  output logic [1:0]    state_dbg
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_hit, frame_ok;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          erro_q, erro_d;
  logic          push_q, push_d;
  logic [9:0]    push_data_q, push_data_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, wr_en;
  logic [9:0]    head;

  // Two-flop synchronizers, then a counter that lets the filtered clock follow only a stable level.
  always_comb begin
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    filt_prev_d = filt_q;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  // Synchronizer and filter registers; the idle PS/2 bus level is 1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // A strobe always wins over the timeout in the same cycle.
  assign timeout_hit = (state_q != IDLE) && !strobe && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign frame_ok    = (^{par_q, shift_q}) && dat_s2_q;

  // Frame FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Frame FSM next state: advance on strobes, abort to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    if (strobe) begin
      case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // Frame datapath: bit shifting, timeout counting, frame evaluation and prefix folding.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    erro_d      = 1'b0;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    if (state_q == IDLE || strobe || timeout_hit) to_cnt_d = '0;
    else                                          to_cnt_d = to_cnt_q + 1'b1;

    if (strobe) begin
      case (state_q)
        IDLE:   bit_cnt_d = '0;
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: par_d = dat_s2_q;
        STOP: begin
          if (!frame_ok) begin
            erro_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = {ext_q, brk_q, shift_q};
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (timeout_hit) begin
      erro_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end
  end

  // Frame datapath registers; push_q stages a completed entry for the FIFO write one edge later.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      erro_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      erro_q      <= erro_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // FIFO control: a pop frees a slot for a push in the same cycle, otherwise a full push is dropped.
  always_comb begin
    pop        = kbd.rd_en && (count_q != '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    wr_en      = push_q && (!full || pop);
    overflow_d = push_q && full && !pop;
    mem_d      = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_data_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
  end

  // FIFO storage and pointers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Show-ahead outputs: head entry straight from storage, forced to 0 while empty.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    kbd.valid      = (count_q != '0);
    kbd.dado       = kbd.valid ? head[7:0] : 8'h00;
    kbd.break_flag = kbd.valid & head[8];
    kbd.extended   = kbd.valid & head[9];
    kbd.erro       = erro_q;
    kbd.overflow   = overflow_q;
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_teclado_ps2.sv
// Directed bench for teclado_ps2: table of frames with expected entries plus hand-written
// sequences for latency, FIFO full, timeout, glitches and mid-frame reset.
module tb_teclado_ps2;
  localparam int FL  = 8;
  localparam int TO  = 2000;
  localparam int FD  = 4;
  localparam int H   = 25;       // half period of the PS/2 clock in system cycles
  localparam int LAT = FL + 4;   // ps2_clk fall -> valid: 2 sync + FL filter + 2 push latency

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [1:0] state_dbg;

  teclado_ps2_if kbd();

  teclado_ps2 #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] exp_q[$];

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (kbd.erro)     err_cnt++;
    if (kbd.overflow) ovf_cnt++;
  end

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       stop_v;
    int         exp_err;
    logic       exp_push;
    logic [9:0] exp_entry;  // {extended, break_flag, dado}
  } vec_t;

  vec_t vecs[13];
  logic [7:0] ob[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_bit(input logic v, input logic glitch);
    ps2_data = v;
    if (glitch) begin
      cycles(13); ps2_clk = 1'b0; cycles(3); ps2_clk = 1'b1; cycles(H - 16);
    end else cycles(H);
    ps2_clk = 1'b0;
    if (glitch) begin
      cycles(13); ps2_clk = 1'b1; cycles(3); ps2_clk = 1'b0; cycles(H - 16);
    end else cycles(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_upto_parity(input logic [7:0] b, input logic bad_par, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_v,
                            input logic glitch);
    send_upto_parity(b, bad_par, glitch);
    send_bit(stop_v, glitch);
    ps2_data = 1'b1;
    cycles(4);
  endtask

  // scoreboard: compare the head with the oldest expected entry, then pop it
  task automatic pop_check(input string name);
    logic [9:0] e;
    e = exp_q.pop_front();
    check({name, " valid"}, kbd.valid, 1);
    check({name, " entry"}, {kbd.extended, kbd.break_flag, kbd.dado}, e);
    kbd.rd_en = 1'b1;
    cycles(1);
    kbd.rd_en = 1'b0;
  endtask

  initial begin
    int e0;
    int o0;
    logic [9:0] e;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 0, 1'b1, 10'h01C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 10'h000};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 0, 1'b1, 10'h11C};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 0, 1'b0, 10'h000};
    vecs[4]  = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 10'h000};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 0, 1'b1, 10'h375};
    vecs[6]  = '{8'h1C, 1'b1, 1'b1, 1, 1'b0, 10'h000};
    vecs[7]  = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 10'h000};
    vecs[8]  = '{8'h32, 1'b0, 1'b0, 1, 1'b0, 10'h000};
    vecs[9]  = '{8'h32, 1'b0, 1'b1, 0, 1'b1, 10'h032};
    vecs[10] = '{8'hE0, 1'b0, 1'b1, 0, 1'b0, 10'h000};
    vecs[11] = '{8'h55, 1'b1, 1'b1, 1, 1'b0, 10'h000};
    vecs[12] = '{8'h12, 1'b0, 1'b1, 0, 1'b1, 10'h012};
    ob[0] = 8'h16; ob[1] = 8'h1E; ob[2] = 8'h26; ob[3] = 8'h25; ob[4] = 8'h2E;

    kbd.rd_en = 1'b0;
    cycles(5);
    check("reset valid",    kbd.valid, 0);
    check("reset dado",     kbd.dado, 0);
    check("reset flags",    {kbd.extended, kbd.break_flag}, 0);
    check("reset erro/ovf", {kbd.erro, kbd.overflow}, 0);
    check("reset state",    state_dbg, 0);
    rst_n = 1'b1;
    cycles(30);

    // exact latency from the stop-bit fall to valid
    send_upto_parity(8'h1C, 1'b0, 1'b0);
    ps2_data = 1'b1;
    cycles(H);
    ps2_clk = 1'b0;
    cycles(LAT - 1);
    check("latency early valid", kbd.valid, 0);
    cycles(1);
    check("latency valid", kbd.valid, 1);
    cycles(H - LAT);
    ps2_clk = 1'b1;
    cycles(4);
    exp_q.push_back(10'h01C);
    pop_check("latency");
    check("latency empty", kbd.valid, 0);
    check("latency erro", err_cnt, 0);

    // table-driven frames
    for (int i = 0; i < 13; i++) begin
      e0 = err_cnt;
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop_v, 1'b0);
      check($sformatf("vec%0d erro", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d valid", i), kbd.valid, vecs[i].exp_push);
      if (vecs[i].exp_push) begin
        exp_q.push_back(vecs[i].exp_entry);
        pop_check($sformatf("vec%0d", i));
      end
      check($sformatf("vec%0d empty", i), kbd.valid, 0);
    end

    // FIFO full without reads: the 5th entry is dropped
    o0 = ovf_cnt;
    for (int k = 0; k < 5; k++) begin
      send_frame(ob[k], 1'b0, 1'b1, 1'b0);
      if (k < 4) exp_q.push_back({2'b00, ob[k]});
      if (k == 3) check("ovf before 5th", ovf_cnt - o0, 0);
    end
    check("ovf on 5th", ovf_cnt - o0, 1);
    for (int k = 0; k < 4; k++) pop_check($sformatf("ovf pop%0d", k));
    check("ovf drained", kbd.valid, 0);

    // FIFO full with a pop on the push edge: both happen, no overflow
    o0 = ovf_cnt;
    for (int k = 0; k < 4; k++) begin
      send_frame(ob[k], 1'b0, 1'b1, 1'b0);
      exp_q.push_back({2'b00, ob[k]});
    end
    send_upto_parity(8'h2E, 1'b0, 1'b0);
    ps2_data = 1'b1;
    cycles(H);
    ps2_clk = 1'b0;
    cycles(LAT - 1);
    e = exp_q.pop_front();
    check("full pop head", {kbd.extended, kbd.break_flag, kbd.dado}, e);
    kbd.rd_en = 1'b1;
    cycles(1);
    kbd.rd_en = 1'b0;
    exp_q.push_back(10'h02E);
    cycles(H - LAT);
    ps2_clk = 1'b1;
    cycles(4);
    check("full pop+push ovf", ovf_cnt - o0, 0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("full pop%0d", k));
    check("full drained", kbd.valid, 0);

    // timeout on a partial frame
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    cycles(1500);
    check("timeout not yet", err_cnt - e0, 0);
    check("timeout still DATA", state_dbg, 1);
    for (int i = 0; i < 1000 && err_cnt == e0; i++) cycles(1);
    check("timeout erro", err_cnt - e0, 1);
    check("timeout state", state_dbg, 0);
    check("timeout valid", kbd.valid, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(10'h01C);
    pop_check("after timeout");
    check("after timeout erro", err_cnt - e0, 1);

    // glitches on ps2_clk during a frame
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("glitch erro", err_cnt - e0, 0);
    exp_q.push_back(10'h01C);
    pop_check("glitch");
    check("glitch empty", kbd.valid, 0);

    // reset in the middle of a frame
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    cycles(3);
    check("midreset state", state_dbg, 0);
    check("midreset valid", kbd.valid, 0);
    rst_n = 1'b1;
    cycles(20);
    check("midreset erro", err_cnt - e0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(10'h01C);
    pop_check("after reset");
    check("after reset empty", kbd.valid, 0);
    check("after reset erro", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // time limit for the whole run
  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied so far", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
